div_258x130_limb: RTL and testbench
===================================

// Module: div_258x130_limb
// PURPOSE
//   Iterative restoring divider: 258-bit dividend / 130-bit divisor -> 258-bit quotient + 130-bit remainder.
//   Inverse of the 130x128 shift-add limb multiplier; takes its 258-bit product (or any wide value) and
//   produces quotient/remainder, e.g. for modular reduction in the GCM/MAC datapath. One quotient bit per
//   cycle, same start/busy/done handshake as the limb multiplier so a controller can chain them directly.
// PARAMETERS
//   DW  258  dividend / quotient width
//   VW  130  divisor / remainder width
// PORTS
//   clk            in   1    clock, rising edge
//   reset_n        in   1    asynchronous, active-low reset
//   start          in   1    request; sampled only while busy==0
//   dividend_in    in   DW   dividend, captured on accepted start
//   divisor_in     in   VW   divisor, captured on accepted start
//   quotient_out   out  DW   quotient, valid when done==1, held until next result
//   remainder_out  out  VW   remainder, valid when done==1, held until next result
//   div_by_zero    out  1    set with done when captured divisor==0; held with results
//   busy           out  1    operation in progress
//   done           out  1    single-cycle result-valid pulse
// BEHAVIOUR
//   Reset (async, any time incl. mid-operation): all outputs 0, all internal state 0, state IDLE;
//     an in-flight operation is discarded with no done pulse.
//   States: IDLE, RUN, DZ.
//   IDLE: start==1 at edge E -> capture operands; bit counter=0; partial remainder R=0 (VW+1 bits);
//     busy=1 from E. If divisor_in==0 -> DZ, else RUN.
//   RUN: each edge consumes one dividend bit, MSB first:
//     T = {R[VW-1:0], next dividend bit}; if T >= divisor: R=T-divisor, q bit=1; else R=T, q bit=0.
//     Compare/subtract at VW+1 bits; no truncation of T before compare.
//     On the DW-th RUN edge (edge E+DW): quotient_out/remainder_out load final values
//     (including the bit computed at that edge), div_by_zero=0, done=1, busy=0, -> IDLE.
//     Latency: done high in cycle E+DW (258 cycles after start edge).
//   DZ: edge E+1: quotient_out=all ones, remainder_out=0, div_by_zero=1, done=1, busy=0, -> IDLE.
//   done is 1 for exactly one cycle; cleared at every other edge.
//   start while busy==1 is ignored (operands not recaptured, no effect on result).
//   start high in the done cycle is accepted (busy already 0): back-to-back ops, no idle gap.
//   Operand inputs need only be stable at the accepting edge.
//   Results invariant: dividend == quotient*divisor + remainder, remainder < divisor (divisor!=0).
//   quotient_out/remainder_out/div_by_zero change only when done asserts (or reset).
// TESTING
//   1) dividend=1000, divisor=7 -> done at start+258, quotient=142, remainder=6, div_by_zero=0.
//   2) dividend=(2^130-1)*(2^128-1), divisor=2^130-1 -> quotient=2^128-1, remainder=0.
//   3) dividend=5, divisor=9 -> quotient=0, remainder=5; dividend=2^258-1, divisor=1 ->
//      quotient=2^258-1, remainder=0.
//   4) divisor=0, dividend=123 -> done at start+1, quotient=all ones, remainder=0, div_by_zero=1.
//   5) start pulsed with new operands at cycles 10 and 100 of an op -> ignored, result of original;
//      start held high in done cycle -> second op accepted, done again 258 cycles later.
//   6) reset_n low at cycle 50 of an op -> outputs 0 immediately, no done; new start after release
//      gives correct result; random regression (10k ops) vs reference model incl. p=2^130-5.

Source files
------------

// File: rtl/div_258x130_limb_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : div_258x130_limb_if                                          |
// | Brief   : start/busy/done handshake + operand/result bus of the divider |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface div_258x130_limb_if #(
  parameter int DW = 258,
  parameter int VW = 130
);
  logic          start;
  logic [DW-1:0] dividend_in;
  logic [VW-1:0] divisor_in;
  logic [DW-1:0] quotient_out;
  logic [VW-1:0] remainder_out;
  logic          div_by_zero;
  logic          busy;
  logic          done;

  modport master (
    output start, dividend_in, divisor_in,
    input  quotient_out, remainder_out, div_by_zero, busy, done
  );

  modport slave (
    input  start, dividend_in, divisor_in,
    output quotient_out, remainder_out, div_by_zero, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/div_258x130_limb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : div_258x130_limb                                             |
// | Brief   : restoring divider, 258b / 130b, one quotient bit per cycle    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module div_258x130_limb #(
  parameter int DW = 258,
  parameter int VW = 130
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  div_258x130_limb_if.slave    bus
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] C_LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DZ   = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  // Dividend shifts out at the top while quotient bits shift in at the bottom.
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] dvs_q;
  // Partial remainder always stays below the divisor, so VW bits hold it.
  logic [VW-1:0] rem_q;

  logic [DW-1:0] quot_q;
  logic [VW-1:0] remo_q;
  logic          dz_q;
  logic          busy_q;
  logic          done_q;

  logic [VW:0]   trial_d;
  logic          ge_d;
  logic [VW-1:0] rem_d;
  logic [DW-1:0] quo_d;

  always_comb begin
    trial_d = {rem_q, dvd_q[DW-1]};
    ge_d    = (trial_d >= {1'b0, dvs_q});
    // True difference is below 2^VW whenever ge_d, so modulo-2^VW subtraction is exact.
    rem_d   = trial_d[VW-1:0] - (ge_d ? dvs_q : {VW{1'b0}});
    quo_d   = {dvd_q[DW-2:0], ge_d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            dvd_q   <= bus.dividend_in;
            dvs_q   <= bus.divisor_in;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (bus.divisor_in == '0) ? DZ : RUN;
          end
        end
        RUN: begin
          dvd_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == C_LAST) begin
            quot_q  <= quo_d;
            remo_q  <= rem_d;
            dz_q    <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        DZ: begin
          quot_q  <= '1;
          remo_q  <= '0;
          dz_q    <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.quotient_out  = quot_q;
  assign bus.remainder_out = remo_q;
  assign bus.div_by_zero   = dz_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_div_258x130_limb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_div_258x130_limb                                          |
// | Brief   : directed vector table + corner sequences for the divider     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_div_258x130_limb;
  localparam int DW = 258;
  localparam int VW = 130;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  div_258x130_limb_if #(.DW(DW), .VW(VW)) bus ();
  div_258x130_limb #(.DW(DW), .VW(VW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] dvd;
    logic [VW-1:0] dvs;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
    int            lat;
  } vec_t;

  vec_t vecs[9];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents operands for one edge; returns at the negedge following the accepting edge.
  task automatic start_op(input logic [DW-1:0] dvd, input logic [VW-1:0] dvs);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.dividend_in = dvd;
    bus.divisor_in  = dvs;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int lat, input vec_t v);
    check({tag, " latency"},   DW'(lat), DW'(v.lat));
    check({tag, " quotient"},  bus.quotient_out, v.q);
    check({tag, " remainder"}, DW'(bus.remainder_out), DW'(v.r));
    check({tag, " dz"},        DW'(bus.div_by_zero), DW'(v.dz));
    check({tag, " busy@done"}, DW'(bus.busy), DW'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " quotient"},  bus.quotient_out, DW'(0));
    check({tag, " remainder"}, DW'(bus.remainder_out), DW'(0));
    check({tag, " dz"},        DW'(bus.div_by_zero), DW'(0));
    check({tag, " busy"},      DW'(bus.busy), DW'(0));
    check({tag, " done"},      DW'(bus.done), DW'(0));
  endtask

  initial begin
    logic [DW-1:0] one, m130, m128, all1, dvd, prev_q;
    logic [VW-1:0] p, dvs;
    vec_t v;
    int   lat;
    logic saw_done;

    one  = DW'(1);
    m130 = (one << 130) - one;
    m128 = (one << 128) - one;
    all1 = '1;
    p    = VW'((one << 130) - DW'(5));

    vecs[0] = '{DW'(1000),   VW'(7),    DW'(142),    VW'(6),    1'b0, 258};
    vecs[1] = '{m130 * m128, VW'(m130), m128,        VW'(0),    1'b0, 258};
    vecs[2] = '{DW'(5),      VW'(9),    DW'(0),      VW'(5),    1'b0, 258};
    vecs[3] = '{all1,        VW'(1),    all1,        VW'(0),    1'b0, 258};
    vecs[4] = '{DW'(123),    VW'(0),    all1,        VW'(0),    1'b1, 1};
    // 2^258-1 = 2^128*(2^130-1) + (2^128-1)
    vecs[5] = '{all1,        VW'(m130), one << 128,  VW'(m128), 1'b0, 258};
    vecs[6] = '{one << 130,  p,         DW'(1),      VW'(5),    1'b0, 258};
    vecs[7] = '{DW'(p),      p,         DW'(1),      VW'(0),    1'b0, 258};
    vecs[8] = '{DW'(0),      VW'(9),    DW'(0),      VW'(0),    1'b0, 258};

    bus.start       = 1'b0;
    bus.dividend_in = '0;
    bus.divisor_in  = '0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].dvd, vecs[i].dvs);
      check($sformatf("vec%0d busy", i), DW'(bus.busy), DW'(1));
      wait_done(lat);
      check_result($sformatf("vec%0d", i), lat, vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d done pulse", i), DW'(bus.done), DW'(0));
    end

    // Starts during an operation must be ignored; previous result stays visible meanwhile.
    prev_q = bus.quotient_out;
    start_op(DW'(1000), VW'(7));
    lat = 0;
    while (bus.done !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
      if (lat == 50) check("held quotient", bus.quotient_out, prev_q);
      bus.start = (lat == 10 || lat == 100);
      if (lat == 10)  begin bus.dividend_in = DW'(5);  bus.divisor_in = VW'(0); end
      if (lat == 100) begin bus.dividend_in = DW'(77); bus.divisor_in = VW'(3); end
    end
    check_result("ignored start", lat, vecs[0]);

    // Back-to-back: start accepted in the done cycle.
    bus.start       = 1'b1;
    bus.dividend_in = one << 130;
    bus.divisor_in  = p;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b busy", DW'(bus.busy), DW'(1));
    check("b2b done", DW'(bus.done), DW'(0));
    wait_done(lat);
    check_result("b2b", lat, vecs[6]);

    // Asynchronous reset mid-operation.
    start_op(DW'(1000), VW'(7));
    saw_done = 1'b0;
    repeat (49) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    #2 reset_n = 1'b0;
    #1 check_all_zero("async reset");
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    check("no done around reset", DW'(saw_done), DW'(0));
    reset_n = 1'b1;
    start_op(DW'(1000), VW'(7));
    wait_done(lat);
    check_result("after reset", lat, vecs[0]);

    // Random operands against a wide-arithmetic reference.
    for (int k = 0; k < 24; k++) begin
      dvd = '0;
      for (int w = 0; w < 9; w++) dvd = (dvd << 32) | DW'($urandom());
      dvs = '0;
      for (int w = 0; w < 5; w++) dvs = (dvs << 32) | VW'($urandom());
      dvs = dvs >> $urandom_range(0, 129);
      if (k % 4 == 0) dvs = p;
      if (dvs == '0) dvs = VW'(1);
      v.dvd = dvd;
      v.dvs = dvs;
      v.q   = dvd / DW'(dvs);
      v.r   = VW'(dvd % DW'(dvs));
      v.dz  = 1'b0;
      v.lat = 258;
      start_op(v.dvd, v.dvs);
      wait_done(lat);
      check_result($sformatf("rand%0d", k), lat, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
